// File: rtl/reverse_flush_sequencer.sv
// Reverse purge sequencer: primes Out1, walks the chip components from last to first
// with per-type dwells and pump-off settle gaps, then drains through Source1.
//
//   state  | meaning
//   IDLE   | waiting for start, all drives off
//   PRIME  | outlet valve open, reverse pump on
//   DWELL  | one component enabled, reverse pump on
//   SETTLE | pump off between components
//   DRAIN  | inlet valve open, reverse pump on
//   DONE   | one-cycle completion pulse
module reverse_flush_sequencer #(
    parameter int                      NUM_STAGES    = 10,
    parameter logic [2*NUM_STAGES-1:0] STAGE_TYPE    = 20'h46148,
    parameter logic [15:0]             MIX_CYCLES    = 16'd4,
    parameter logic [15:0]             HEAT_CYCLES   = 16'd6,
    parameter logic [15:0]             FILT_CYCLES   = 16'd8,
    parameter logic [15:0]             SETTLE_CYCLES = 16'd2,
    parameter logic [15:0]             PRIME_CYCLES  = 16'd3,
    parameter logic [7:0]              PASSES        = 8'd1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  aborted_o,
    output logic [NUM_STAGES-1:0] stage_en_o,
    output logic                  pump_rev_o,
    output logic                  outlet_valve_o,
    output logic                  inlet_valve_o,
    output logic [3:0]            stage_idx_o,
    output logic [7:0]            pass_cnt_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRIME  = 3'd1;
    localparam logic [2:0] S_DWELL  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [3:0]            idx_q, idx_d;
    logic [7:0]            pass_q, pass_d;
    logic                  done_d, aborted_d;
    logic [NUM_STAGES-1:0] stage_en_d;
    logic [4:0]            first_hit, below_hit;
    logic                  nxt_valid;
    logic [3:0]            nxt_idx;
    logic [7:0]            nxt_pass;

    function automatic logic [15:0] dwell_of(input logic [3:0] i);
        logic [1:0] ty;
        ty = 2'(STAGE_TYPE >> {i, 1'b0});
        case (ty)
            2'd0:    return MIX_CYCLES;
            2'd1:    return HEAT_CYCLES;
            default: return FILT_CYCLES;
        endcase
    endfunction

    // Highest non-skip stage strictly below 'from'; bit 4 flags that one exists.
    function automatic logic [4:0] find_below(input logic [4:0] from);
        logic [4:0] r;
        r = '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            if (5'(j) < from && 2'(STAGE_TYPE >> (2 * j)) != 2'd3) begin
                r = {1'b1, 4'(j)};
            end
        end
        return r;
    endfunction

    always_comb begin
        first_hit = find_below(5'(NUM_STAGES));
        below_hit = find_below({1'b0, idx_q});
        nxt_valid = 1'b0;
        nxt_idx   = idx_q;
        nxt_pass  = pass_q;
        if (below_hit[4]) begin
            nxt_valid = 1'b1;
            nxt_idx   = below_hit[3:0];
        end else if (pass_q < PASSES - 8'd1 && first_hit[4]) begin
            nxt_valid = 1'b1;
            nxt_idx   = first_hit[3:0];
            nxt_pass  = pass_q + 8'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_PRIME;
                    cnt_d   = PRIME_CYCLES;
                    idx_d   = 4'(NUM_STAGES - 1);
                    pass_d  = 8'd0;
                end
            end
            S_PRIME: begin
                if (cnt_q == 16'd1) begin
                    if (first_hit[4]) begin
                        state_d = S_DWELL;
                        idx_d   = first_hit[3:0];
                        cnt_d   = dwell_of(first_hit[3:0]);
                    end else begin
                        state_d = S_DRAIN;
                        cnt_d   = PRIME_CYCLES;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DWELL: begin
                if (cnt_q == 16'd1) begin
                    if (!nxt_valid) begin
                        state_d = S_DRAIN;
                        cnt_d   = PRIME_CYCLES;
                    end else if (SETTLE_CYCLES != 16'd0) begin
                        state_d = S_SETTLE;
                        cnt_d   = SETTLE_CYCLES;
                    end else begin
                        idx_d  = nxt_idx;
                        pass_d = nxt_pass;
                        cnt_d  = dwell_of(nxt_idx);
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_SETTLE: begin
                // stage_idx holds the finished stage until the next dwell begins
                if (cnt_q == 16'd1) begin
                    state_d = S_DWELL;
                    idx_d   = nxt_idx;
                    pass_d  = nxt_pass;
                    cnt_d   = dwell_of(nxt_idx);
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == 16'd1) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_i && state_q != S_IDLE && state_q != S_DONE) begin
            state_d   = S_IDLE;
            cnt_d     = 16'd0;
            done_d    = 1'b0;
            aborted_d = 1'b1;
        end
    end

    always_comb begin
        stage_en_d = '0;
        if (state_d == S_DWELL) begin
            stage_en_d = NUM_STAGES'(1) << idx_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            cnt_q          <= 16'd0;
            idx_q          <= 4'd0;
            pass_q         <= 8'd0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            aborted_o      <= 1'b0;
            stage_en_o     <= '0;
            pump_rev_o     <= 1'b0;
            outlet_valve_o <= 1'b0;
            inlet_valve_o  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            pass_q         <= pass_d;
            busy_o         <= state_d inside {S_PRIME, S_DWELL, S_SETTLE, S_DRAIN};
            done_o         <= done_d;
            aborted_o      <= aborted_d;
            stage_en_o     <= stage_en_d;
            pump_rev_o     <= state_d inside {S_PRIME, S_DWELL, S_DRAIN};
            outlet_valve_o <= (state_d == S_PRIME);
            inlet_valve_o  <= (state_d == S_DRAIN);
        end
    end

    assign stage_idx_o = idx_q;
    assign pass_cnt_o  = pass_q;

endmodule

// File: tb/tb_reverse_flush_sequencer.sv
// Directed bench for reverse_flush_sequencer: default, two-pass and skip/no-settle
// instances checked cycle by cycle against hand-tabulated dwell schedules.
module tb_reverse_flush_sequencer;

    typedef logic [15:0] vec_t;
    typedef struct {
        vec_t v;
        int   idx;
        int   pas;
    } step_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       abort_s;
    logic [2:0] start_w;
    logic [2:0] busy_w, done_w, aborted_w, pump_w, outv_w, inv_w;
    logic [9:0] en_w   [3];
    logic [3:0] idx_w  [3];
    logic [7:0] pass_w [3];

    int    tests = 0;
    int    fails = 0;
    step_t exp_q[$];
    int    dw_def  [10] = '{4, 8, 4, 6, 6, 4, 8, 6, 4, 6};
    int    dw_skip [10] = '{4, 8, 4, 6, 0, 4, 8, 6, 4, 6};

    always #5 clk = ~clk;

    reverse_flush_sequencer u_def (
        .clk_i(clk), .rst_i(rst), .start_i(start_w[0]), .abort_i(abort_s),
        .busy_o(busy_w[0]), .done_o(done_w[0]), .aborted_o(aborted_w[0]),
        .stage_en_o(en_w[0]), .pump_rev_o(pump_w[0]), .outlet_valve_o(outv_w[0]),
        .inlet_valve_o(inv_w[0]), .stage_idx_o(idx_w[0]), .pass_cnt_o(pass_w[0])
    );

    reverse_flush_sequencer #(.PASSES(8'd2)) u_two (
        .clk_i(clk), .rst_i(rst), .start_i(start_w[1]), .abort_i(abort_s),
        .busy_o(busy_w[1]), .done_o(done_w[1]), .aborted_o(aborted_w[1]),
        .stage_en_o(en_w[1]), .pump_rev_o(pump_w[1]), .outlet_valve_o(outv_w[1]),
        .inlet_valve_o(inv_w[1]), .stage_idx_o(idx_w[1]), .pass_cnt_o(pass_w[1])
    );

    reverse_flush_sequencer #(.STAGE_TYPE(20'h46348), .SETTLE_CYCLES(16'd0)) u_skp (
        .clk_i(clk), .rst_i(rst), .start_i(start_w[2]), .abort_i(abort_s),
        .busy_o(busy_w[2]), .done_o(done_w[2]), .aborted_o(aborted_w[2]),
        .stage_en_o(en_w[2]), .pump_rev_o(pump_w[2]), .outlet_valve_o(outv_w[2]),
        .inlet_valve_o(inv_w[2]), .stage_idx_o(idx_w[2]), .pass_cnt_o(pass_w[2])
    );

    function automatic vec_t mk(bit b, bit d, bit a, bit p, bit o, bit i, logic [9:0] en);
        return {b, d, a, p, o, i, en};
    endfunction

    function automatic vec_t obs(int s);
        return {busy_w[s], done_w[s], aborted_w[s], pump_w[s], outv_w[s], inv_w[s], en_w[s]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic push(input vec_t v, input int idx, input int pas, input int n);
        step_t s;
        s.v = v;
        s.idx = idx;
        s.pas = pas;
        repeat (n) exp_q.push_back(s);
    endtask

    // Schedule as seen from the cycle after the start edge: prime, dwells, drain, done, idle.
    task automatic build(input int dw[10], input int settle, input int passes);
        bit first;
        first = 1'b1;
        exp_q.delete();
        push(mk(1, 0, 0, 1, 1, 0, 10'd0), -1, -1, 3);
        for (int p = 0; p < passes; p++) begin
            for (int s = 9; s >= 0; s--) begin
                if (dw[s] != 0) begin
                    if (!first && settle > 0) push(mk(1, 0, 0, 0, 0, 0, 10'd0), -1, -1, settle);
                    first = 1'b0;
                    push(mk(1, 0, 0, 1, 0, 0, 10'd1 << s), s, p, dw[s]);
                end
            end
        end
        push(mk(1, 0, 0, 1, 0, 1, 10'd0), -1, -1, 3);
        push(mk(0, 1, 0, 0, 0, 0, 10'd0), -1, -1, 1);
        push(mk(0, 0, 0, 0, 0, 0, 10'd0), -1, -1, 1);
    endtask

    task automatic check_trace(input int sel, input int from, input int n, input string nm);
        for (int k = from; k < from + n; k++) begin
            chk($sformatf("%s_c%0d_out", nm, k + 1), 32'(obs(sel)), 32'(exp_q[k].v));
            if (exp_q[k].idx >= 0) begin
                chk($sformatf("%s_c%0d_idx", nm, k + 1), {20'd0, idx_w[sel], pass_w[sel]},
                    {20'd0, 4'(exp_q[k].idx), 8'(exp_q[k].pas)});
            end
            tick();
        end
    endtask

    initial begin
        bit got;
        rst = 1'b1;
        abort_s = 1'b0;
        start_w = 3'b000;
        tick();
        tick();
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("reset_out_%0d", s), 32'(obs(s)), 32'd0);
            chk($sformatf("reset_idx_%0d", s), {20'd0, idx_w[s], pass_w[s]}, 32'd0);
        end
        tick();

        // Default single pass: busy cycles 1..80, done at 81.
        build(dw_def, 2, 1);
        start_w[0] = 1'b1;
        tick();
        start_w[0] = 1'b0;
        check_trace(0, 0, exp_q.size(), "def");

        // Two passes: 156 busy cycles, wrap to stage 9 with pass 1.
        build(dw_def, 2, 2);
        chk("two_pass_len", 32'(exp_q.size()), 32'd158);
        start_w[1] = 1'b1;
        tick();
        start_w[1] = 1'b0;
        check_trace(1, 0, exp_q.size(), "two");

        // Stage 4 skipped, no settle gaps: 56 busy cycles.
        build(dw_skip, 0, 1);
        chk("skip_len", 32'(exp_q.size()), 32'd58);
        start_w[2] = 1'b1;
        tick();
        start_w[2] = 1'b0;
        check_trace(2, 0, exp_q.size(), "skp");

        // Abort in the middle of stage 5 dwell.
        build(dw_def, 2, 1);
        start_w[0] = 1'b1;
        tick();
        start_w[0] = 1'b0;
        check_trace(0, 0, 36, "pre_abort");
        chk("abort_at_stage5", {18'd0, en_w[0], idx_w[0]}, {18'd0, 10'b0000100000, 4'd5});
        abort_s = 1'b1;
        tick();
        abort_s = 1'b0;
        chk("aborted_pulse", 32'(obs(0)), 32'(mk(0, 0, 1, 0, 0, 0, 10'd0)));
        tick();
        chk("post_abort_idle", 32'(obs(0)), 32'd0);
        start_w[0] = 1'b1;
        abort_s = 1'b1;
        tick();
        start_w[0] = 1'b0;
        abort_s = 1'b0;
        check_trace(0, 0, 80, "restart");
        chk("restart_done", 32'(obs(0)), 32'(mk(0, 1, 0, 0, 0, 0, 10'd0)));
        abort_s = 1'b1;
        tick();
        abort_s = 1'b0;
        chk("abort_in_done_ignored", 32'(obs(0)), 32'd0);
        abort_s = 1'b1;
        tick();
        abort_s = 1'b0;
        chk("abort_in_idle_ignored", 32'(obs(0)), 32'd0);

        // Start held high through a run: mid-run start ignored, second run follows DONE.
        start_w[0] = 1'b1;
        tick();
        check_trace(0, 0, 81, "held");
        got = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            if (busy_w[0]) got = 1'b1;
            else tick();
        end
        chk("held_restart_seen", 32'(got), 32'd1);
        start_w[0] = 1'b0;
        check_trace(0, 0, exp_q.size(), "held2");

        // Reset during DRAIN: everything clears, no done or aborted afterwards.
        start_w[0] = 1'b1;
        tick();
        start_w[0] = 1'b0;
        check_trace(0, 0, 78, "pre_rst");
        chk("in_drain", 32'(obs(0)), 32'(mk(1, 0, 0, 1, 0, 1, 10'd0)));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_drain_out", 32'(obs(0)), 32'd0);
        chk("rst_drain_idx", {20'd0, idx_w[0], pass_w[0]}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rst_idle_%0d", k), 32'(obs(0)), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
